// File: rtl/data_packer_pkg.sv
// Shared constants and types for the device-to-host byte-to-word packer.
// PAD_BYTE_DEFAULT is also used by the unpacker bench.
package data_packer_pkg;
    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);
    localparam int COUNT_W    = LANE_W + 1;
    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

    typedef enum logic {FILL = 1'b0, OUT = 1'b1} pack_state_e;

    typedef logic [WORD_BYTES-1:0][7:0] lanes_t;

    // Little-endian assembly: lanes at or above nbytes are replaced by pad.
    function automatic logic [8*WORD_BYTES-1:0] pack_lanes(
        input lanes_t             lanes,
        input logic [COUNT_W-1:0] nbytes,
        input logic [7:0]         pad
    );
        logic [8*WORD_BYTES-1:0] word;
        word = '0;
        for (int i = 0; i < WORD_BYTES; i++)
            word[8*i +: 8] = (i < int'(nbytes)) ? lanes[i] : pad;
        return word;
    endfunction
endpackage

// File: rtl/data_packer.sv
// Pops bytes from a registered-read FIFO and packs them little-endian into 32-bit words,
// with a flush that emits a padded partial word.
//   state | meaning
//   FILL  | collecting bytes, pops allowed
//   OUT   | word held on data/data_valid until data_ready
module data_packer
    import data_packer_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
    input  logic        clk_pll,
    input  logic        reset,
    input  logic [7:0]  FIFO_output_data,
    input  logic        FIFO_empty,
    output logic        FIFO_pop_data,
    input  logic        flush,
    output logic [31:0] data,
    output logic [2:0]  data_bytes,
    output logic        data_valid,
    input  logic        data_ready
);

    pack_state_e        state_q;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               inflight_q;
    logic               flush_pending_q;
    lanes_t             lanes_q, lanes_d;
    logic [31:0]        data_q;
    logic [2:0]         data_bytes_q;
    logic               data_valid_q;
    logic [COUNT_W-1:0] occupancy;
    logic               pop;

    assign occupancy = count_q + {{(COUNT_W-1){1'b0}}, inflight_q};

    assign pop = !reset && (state_q == FILL) && !FIFO_empty && !flush_pending_q
                 && (occupancy < COUNT_W'(WORD_BYTES));

    // Byte popped last cycle lands in the next free lane at this edge.
    always_comb begin
        count_d = count_q;
        lanes_d = lanes_q;
        if (inflight_q) begin
            lanes_d[count_q[LANE_W-1:0]] = FIFO_output_data;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            state_q         <= FILL;
            count_q         <= '0;
            inflight_q      <= 1'b0;
            flush_pending_q <= 1'b0;
            lanes_q         <= '0;
            data_q          <= '0;
            data_bytes_q    <= '0;
            data_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    count_q    <= count_d;
                    lanes_q    <= lanes_d;
                    inflight_q <= pop;
                    if (count_d == COUNT_W'(WORD_BYTES)) begin
                        data_q          <= pack_lanes(lanes_d, count_d, PAD_BYTE);
                        data_bytes_q    <= count_d;
                        data_valid_q    <= 1'b1;
                        state_q         <= OUT;
                        count_q         <= '0;
                        flush_pending_q <= 1'b0;
                    end else if ((flush || flush_pending_q) && !pop) begin
                        flush_pending_q <= 1'b0;
                        if (count_d != '0) begin
                            data_q       <= pack_lanes(lanes_d, count_d, PAD_BYTE);
                            data_bytes_q <= count_d;
                            data_valid_q <= 1'b1;
                            state_q      <= OUT;
                            count_q      <= '0;
                        end
                    end else if (flush) begin
                        flush_pending_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (data_valid_q && data_ready) begin
                        data_valid_q <= 1'b0;
                        state_q      <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign FIFO_pop_data = pop;
    assign data          = data_q;
    assign data_bytes    = data_bytes_q;
    assign data_valid    = data_valid_q;

endmodule

// File: tb/tb_data_packer.sv
// Directed bench for data_packer: a queue-based model of the byte stream is checked against
// the DUT every cycle, plus literal expectations on key words and timings.
module tb_data_packer;
    import data_packer_pkg::*;

    logic        clk_pll = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  FIFO_output_data = 8'h00;
    logic        FIFO_empty = 1'b1;
    logic        FIFO_pop_data;
    logic        flush = 1'b0;
    logic [31:0] data;
    logic [2:0]  data_bytes;
    logic        data_valid;
    logic        data_ready = 1'b0;

    data_packer #(.PAD_BYTE(8'h00)) dut (
        .clk_pll          (clk_pll),
        .reset            (reset),
        .FIFO_output_data (FIFO_output_data),
        .FIFO_empty       (FIFO_empty),
        .FIFO_pop_data    (FIFO_pop_data),
        .flush            (flush),
        .data             (data),
        .data_bytes       (data_bytes),
        .data_valid       (data_valid),
        .data_ready       (data_ready)
    );

    always #5 clk_pll = ~clk_pll;

    int n_tests = 0;
    int n_fail  = 0;

    // Upstream FIFO contents and the model's own copy of the same byte stream.
    logic [7:0] fifo_q[$];
    logic [7:0] exp_stream[$];
    logic       starve_en = 1'b0;

    // Model: bytes captured so far, at most one byte on its way from the FIFO.
    logic [7:0]  m_bytes[$];
    logic        m_infl = 1'b0;
    logic [7:0]  m_infl_b = 8'h00;
    logic        m_pend = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    logic [2:0]  m_nb = '0;

    logic        s_pop, s_valid, s_flush, s_ready;
    logic [31:0] s_data;
    logic [2:0]  s_bytes;
    logic [31:0] pop_hist, val_hist;
    logic [31:0] words [2];
    int          nw;
    logic        prev_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_bytes.delete();
        m_infl  = 1'b0;
        m_pend  = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_nb    = '0;
    endtask

    task automatic model_emit();
        m_data = '0;
        for (int i = 0; i < WORD_BYTES; i++)
            m_data[8*i +: 8] = (i < m_bytes.size()) ? m_bytes[i] : PAD_BYTE_DEFAULT;
        m_nb    = 3'(m_bytes.size());
        m_valid = 1'b1;
        m_bytes.delete();
    endtask

    task automatic model_step(input logic p);
        if (m_valid) begin
            if (s_ready) m_valid = 1'b0;
        end else begin
            if (m_infl) m_bytes.push_back(m_infl_b);
            m_infl = p;
            if (p) begin
                if (exp_stream.size() > 0) m_infl_b = exp_stream.pop_front();
                else                       m_infl_b = 8'h00;
            end
            if (m_bytes.size() == WORD_BYTES) begin
                model_emit();
                m_pend = 1'b0;
            end else if ((s_flush || m_pend) && !p) begin
                if (m_bytes.size() > 0) model_emit();
                m_pend = 1'b0;
            end else if (s_flush) begin
                m_pend = 1'b1;
            end
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance model and FIFO after the rise.
    task automatic tick();
        logic exp_pop;
        @(negedge clk_pll);
        exp_pop = !reset && !m_valid && !FIFO_empty && !m_pend
                  && ((m_bytes.size() + (m_infl ? 1 : 0)) < WORD_BYTES);
        s_pop   = FIFO_pop_data;
        s_valid = data_valid;
        s_data  = data;
        s_bytes = data_bytes;
        s_flush = flush;
        s_ready = data_ready;
        check("pop", 32'(FIFO_pop_data), 32'(exp_pop));
        check("pop_while_empty", 32'(FIFO_pop_data & FIFO_empty), 32'd0);
        check("valid", 32'(data_valid), 32'(m_valid));
        if (m_valid) begin
            check("data", data, m_data);
            check("data_bytes", 32'(data_bytes), 32'(m_nb));
        end
        @(posedge clk_pll);
        #1;
        if (reset) begin
            model_clear();
            fifo_q.delete();
            exp_stream.delete();
            FIFO_output_data = 8'h00;
        end else begin
            model_step(exp_pop);
            if (s_pop && fifo_q.size() > 0) FIFO_output_data = fifo_q.pop_front();
        end
        FIFO_empty = starve_en | (fifo_q.size() == 0);
    endtask

    task automatic push_bytes(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(w[8*i +: 8]);
            exp_stream.push_back(w[8*i +: 8]);
        end
        FIFO_empty = starve_en | (fifo_q.size() == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick();
        check("rst_data", s_data, 32'd0);
        check("rst_bytes", 32'(s_bytes), 32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Full word, consumer always ready
        data_ready = 1'b1;
        push_bytes(32'h44332211, 4);
        pop_hist = '0; val_hist = '0;
        for (int k = 0; k < 7; k++) begin
            tick();
            pop_hist[k] = s_pop;
            val_hist[k] = s_valid;
            if (k == 5) begin
                check("fw_data", s_data, 32'h44332211);
                check("fw_bytes", 32'(s_bytes), 32'd4);
            end
        end
        check("fw_pops", pop_hist, 32'h0000000F);
        check("fw_valid", val_hist, 32'h00000020);

        // Backpressure for 10 cycles, flush pulse while holding is ignored
        data_ready = 1'b0;
        push_bytes(32'h44332211, 4);
        push_bytes(32'h88776655, 4);
        pop_hist = '0; val_hist = '0;
        for (int k = 0; k < 23; k++) begin
            flush = (k == 8);
            if (k == 15) data_ready = 1'b1;
            tick();
            pop_hist[k] = s_pop;
            val_hist[k] = s_valid;
            if (k >= 5 && k <= 15) check("bp_hold_data", s_data, 32'h44332211);
            if (k == 21) begin
                check("bp_word2_data", s_data, 32'h88776655);
                check("bp_word2_bytes", 32'(s_bytes), 32'd4);
            end
        end
        flush = 1'b0;
        check("bp_pops", pop_hist, 32'h000F000F);
        check("bp_valid", val_hist, 32'h0020FFE0);

        // Partial flush with two bytes
        push_bytes(32'h0000BBAA, 2);
        for (int k = 0; k < 6; k++) begin
            flush = (k == 3);
            tick();
            if (k == 4) begin
                check("pf_valid", 32'(s_valid), 32'd1);
                check("pf_data", s_data, 32'h0000BBAA);
                check("pf_bytes", 32'(s_bytes), 32'd2);
            end
        end
        flush = 1'b0;

        // Flush the cycle after the third pop: the in-flight byte still lands
        push_bytes(32'h00C3C2C1, 3);
        for (int k = 0; k < 6; k++) begin
            flush = (k == 3);
            tick();
            if (k == 4) begin
                check("fi_valid", 32'(s_valid), 32'd1);
                check("fi_data", s_data, 32'h00C3C2C1);
                check("fi_bytes", 32'(s_bytes), 32'd3);
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("zf_no_valid", 32'(s_valid), 32'd0);
        end
        push_bytes(32'hD4D3D2D1, 4);
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 0) check("zf_pop_resumes", 32'(s_pop), 32'd1);
            if (k == 5) check("zf_word", s_data, 32'hD4D3D2D1);
        end

        // Flush coinciding with the fourth capture
        push_bytes(32'hE4E3E2E1, 4);
        val_hist = '0;
        for (int k = 0; k < 10; k++) begin
            flush = (k == 4);
            tick();
            val_hist[k] = s_valid;
            if (k == 5) begin
                check("f4_data", s_data, 32'hE4E3E2E1);
                check("f4_bytes", 32'(s_bytes), 32'd4);
            end
        end
        flush = 1'b0;
        check("f4_valid", val_hist, 32'h00000020);

        // Starved FIFO: empty every other cycle
        push_bytes(32'hF4F3F2F1, 4);
        push_bytes(32'h78563412, 4);
        nw = 0;
        prev_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            starve_en  = ((k % 2) == 1);
            FIFO_empty = starve_en | (fifo_q.size() == 0);
            tick();
            if (s_valid && !prev_valid && nw < 2) begin
                words[nw] = s_data;
                nw++;
            end
            prev_valid = s_valid;
        end
        starve_en  = 1'b0;
        FIFO_empty = (fifo_q.size() == 0);
        check("sv_words", 32'(nw), 32'd2);
        check("sv_word0", words[0], 32'hF4F3F2F1);
        check("sv_word1", words[1], 32'h78563412);

        // Async reset after two bytes captured
        push_bytes(32'h04030201, 4);
        for (int k = 0; k < 3; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("ar_data", data, 32'd0);
        check("ar_bytes", 32'(data_bytes), 32'd0);
        check("ar_valid", 32'(data_valid), 32'd0);
        check("ar_pop", 32'(FIFO_pop_data), 32'd0);
        fifo_q.delete();
        exp_stream.delete();
        FIFO_output_data = 8'h00;
        FIFO_empty = 1'b1;
        model_clear();
        tick();
        reset = 1'b0;
        push_bytes(32'h8D7C6B5A, 4);
        pop_hist = '0;
        for (int k = 0; k < 7; k++) begin
            tick();
            pop_hist[k] = s_pop;
            if (k == 5) begin
                check("ar_word", s_data, 32'h8D7C6B5A);
                check("ar_word_bytes", 32'(s_bytes), 32'd4);
            end
        end
        check("ar_pops", pop_hist, 32'h0000000F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_packer.md
Name: data_packer

Overview:
- Byte-to-word packer for the device-to-host path.
- Pops bytes from an upstream byte FIFO with one-cycle registered read latency and assembles them little-endian into 32-bit words: first byte into data[7:0].
- Presents each word on a valid/ready interface toward the USB transmit logic.
- Supports a flush request that emits a zero-padded partial word, so short packets are not stranded.

Parameters:
- PAD_BYTE, 8'h00, value written into unfilled byte lanes of a flushed partial word.

Ports:
- clk_pll  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- FIFO_output_data  input  8  byte from the upstream FIFO; valid the cycle after FIFO_pop_data was high.
- FIFO_empty  input  1  upstream FIFO has no bytes.
- FIFO_pop_data  output  1  pop request; combinational.
- flush  input  1  single-cycle request to emit the current partial word.
- data  output  32  assembled word, registered.
- data_bytes  output  3  number of valid bytes in data (1..4), registered.
- data_valid  output  1  word available, registered.
- data_ready  input  1  consumer accepts the word when high at a rising edge together with data_valid.

Behaviour:
- Clock and reset: one clock (clk_pll); reset is asynchronous and active-high.
- Reset values:
  - data=0, data_bytes=0, data_valid=0.
  - State FILL; byte count=0; in-flight flag=0; flush_pending=0.
  - FIFO_pop_data is forced 0 while reset is high.
- States:
  - FILL: collecting bytes.
  - OUT: word held on the output.
- FIFO_pop_data = (state==FILL) & !FIFO_empty & !flush_pending & (count + inflight < 4).
- A pop in cycle t sets inflight for cycle t+1. At the end of cycle t+1:
  - FIFO_output_data is written to lane count;
  - count increments;
  - inflight clears, unless a new pop was issued in t+1.
- Back-to-back pops are allowed: count+inflight never exceeds 4.
- Word completion: at the edge that captures the 4th byte, data is loaded with all four lanes, data_bytes=4, data_valid=1, and state goes to OUT with count=0.
- Latency: pops in cycles 0-3 give data_valid high from cycle 5.
- OUT state:
  - data, data_bytes and data_valid are held stable and no pops are issued.
  - Leave OUT on the edge where data_valid & data_ready: data_valid goes to 0 and state returns to FILL.
  - Peak throughput is one word per 6 cycles with data_ready tied high.
- data_ready while data_valid=0 is ignored.
- Flush:
  - flush sampled high in FILL sets flush_pending; new pops stop.
  - Once inflight=0 and the byte is captured:
    - if count>0: emit data with lanes >= count set to PAD_BYTE, data_bytes=count, go to OUT, count=0, clear flush_pending;
    - if count==0: clear flush_pending only; no word is emitted.
  - flush on the same cycle the 4th byte is captured: the full word is emitted with data_bytes=4; the flush is consumed as a no-op.
  - flush in OUT is ignored.
- FIFO_empty rising while inflight=1: the in-flight byte is still captured. Only new pops are suppressed.
- Reset mid-word: partial bytes and any in-flight byte are discarded. The upstream FIFO is expected to be reset on the same reset.

Decomposition:
- Shared package holds:
  - WORD_BYTES=4;
  - the lane index width;
  - the two-value state enum {FILL, OUT};
  - the PAD_BYTE default constant, shared with the unpacker's bench.
- No sub-module: a single always block for state, count, inflight and lanes, plus one continuous assignment for FIFO_pop_data.

Test Plan:
- Full word: FIFO holds 8'h11,22,33,44 and data_ready=1. Expect pops in cycles 0-3, data_valid high in cycle 5 with data=32'h44332211 and data_bytes=4, then deasserted after one cycle.
- Backpressure: two words queued and data_ready=0 for 10 cycles. Expect the first word held stable with no pops. After data_ready rises, the second word 32'h88776655 appears 6 cycles after acceptance.
- Partial flush: FIFO supplies 8'hAA,8'hBB then goes empty; pulse flush. Expect data=32'h0000BBAA and data_bytes=2.
- Flush with inflight/empty: flush in the cycle after the 3rd pop. Expect the 3rd byte captured and data_bytes=3. Then flush with count=0: expect no data_valid and flush_pending cleared.
- Starved FIFO: FIFO_empty toggles every other cycle. Expect FIFO_pop_data never high while FIFO_empty=1 and correct byte order preserved.
- Async reset: assert reset mid-way between edges after 2 bytes are captured. Expect all outputs 0 immediately; a subsequent 4-byte sequence packs from lane 0.
